// File: rtl/button_debouncer_pkg.sv
// button_debouncer_pkg: press FSM states and defaults shared with the button controller.
package button_debouncer_pkg;
   typedef enum logic [1:0] {IDLE, ACTIVE, REJECT, WAIT_REL} state_t;
   localparam int N_BUTTONS_DEF = 9;
   localparam int DEBOUNCE_CYCLES_DEF = 500000;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: two-flop synchroniser followed by a stable-count debouncer for one button.
module debounce_bit
   import button_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clock,
   input  logic resetn,
   input  logic raw,
   output logic deb
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   logic             sync1_q, sync2_q, deb_q, deb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      // Any sample matching the current level restarts the count.
      if (sync2_q != deb_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) deb_d = sync2_q;
         else cnt_d = cnt_q + CNT_W'(1);
      end
   end
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
      end
   end
   assign deb = deb_q;
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: debounces every button and emits one clean one-hot pulse per accepted press.
module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int N_BUTTONS       = N_BUTTONS_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int PULSE_CYCLES    = 1
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic [N_BUTTONS-1:0] raw_buttons,
   output logic [N_BUTTONS-1:0] buttons,
   output logic                 press_valid,
   output logic                 rejected
);
   localparam int TMR_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   logic [N_BUTTONS-1:0] deb, buttons_q, buttons_d;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic                 press_valid_q, press_valid_d, rejected_q, rejected_d;
   state_t               state_q, state_d;
   for (genvar i = 0; i < N_BUTTONS; i++) begin : g_deb
      debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clock  (clock),
         .resetn (resetn),
         .raw    (raw_buttons[i]),
         .deb    (deb[i])
      );
   end
   always_comb begin
      state_d       = state_q;
      buttons_d     = buttons_q;
      timer_d       = timer_q;
      press_valid_d = 1'b0;
      rejected_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if ($onehot(deb)) begin
               state_d       = ACTIVE;
               buttons_d     = deb;
               press_valid_d = 1'b1;
               timer_d       = TMR_W'(PULSE_CYCLES - 1);
            end else if (deb != '0) begin
               state_d    = REJECT;
               rejected_d = 1'b1;
               buttons_d  = '0;
            end
         end
         // The latched selection is held regardless of further deb activity.
         ACTIVE: begin
            if (timer_q == '0) begin
               state_d   = WAIT_REL;
               buttons_d = '0;
            end else timer_d = timer_q - TMR_W'(1);
         end
         REJECT: state_d = WAIT_REL;
         default: begin
            buttons_d = '0;
            if (deb == '0) state_d = IDLE;
         end
      endcase
   end
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q       <= IDLE;
         buttons_q     <= '0;
         timer_q       <= '0;
         press_valid_q <= 1'b0;
         rejected_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         buttons_q     <= buttons_d;
         timer_q       <= timer_d;
         press_valid_q <= press_valid_d;
         rejected_q    <= rejected_d;
      end
   end
   assign buttons     = buttons_q;
   assign press_valid = press_valid_q;
   assign rejected    = rejected_q;
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed checks of debounce latency, pulse shaping, rejection and reset.
module tb_button_debouncer;
   logic       clock, resetn;
   logic [8:0] raw, buttons, b1;
   logic       press_valid, rejected, pv1, rj1;
   int         checks = 0;
   int         passes = 0;

   button_debouncer #(.N_BUTTONS(9), .DEBOUNCE_CYCLES(4), .PULSE_CYCLES(2)) dut (
      .clock(clock), .resetn(resetn), .raw_buttons(raw),
      .buttons(buttons), .press_valid(press_valid), .rejected(rejected));

   button_debouncer #(.N_BUTTONS(9), .DEBOUNCE_CYCLES(4), .PULSE_CYCLES(1)) dut1 (
      .clock(clock), .resetn(resetn), .raw_buttons(raw),
      .buttons(b1), .press_valid(pv1), .rejected(rj1));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick();
      @(posedge clock);
      #1;
      checks++;
      if ($countones(buttons) > 1 || $countones(b1) > 1)
         $display("FAIL onehot: buttons=%b b1=%b, required at most one bit set", buttons, b1);
      else passes++;
   endtask

   task automatic do_reset();
      raw = '0;
      resetn = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      raw = 9'h1FF;
      #3;
      checks++;
      if (buttons !== 9'h0 || press_valid !== 1'b0 || rejected !== 1'b0)
         $display("FAIL reset: buttons=%b pv=%b rej=%b, required all zero", buttons, press_valid, rejected);
      else passes++;
      do_reset();
   endtask

   task automatic test_press();
      logic [8:0] eb, eb1;
      do_reset();
      raw = 9'h004;
      for (int c = 1; c <= 15; c++) begin
         tick();
         eb  = (c == 7 || c == 8) ? 9'h004 : 9'h000;
         eb1 = (c == 7) ? 9'h004 : 9'h000;
         checks++;
         if (buttons !== eb || press_valid !== (c == 7) || rejected !== 1'b0)
            $display("FAIL press c=%0d: buttons=%b pv=%b rej=%b, required %b pv=%b rej=0", c, buttons, press_valid, rejected, eb, c == 7);
         else passes++;
         checks++;
         if (b1 !== eb1 || pv1 !== (c == 7))
            $display("FAIL press_p1 c=%0d: b1=%b pv1=%b, required %b pv1=%b", c, b1, pv1, eb1, c == 7);
         else passes++;
      end
   endtask

   task automatic test_bounce();
      do_reset();
      for (int c = 0; c < 30; c++) begin
         raw = (c < 20 && ((c >> 1) & 1) == 0) ? 9'h001 : 9'h000;
         tick();
         checks++;
         if (buttons !== 9'h0 || press_valid !== 1'b0 || rejected !== 1'b0)
            $display("FAIL bounce c=%0d: buttons=%b pv=%b rej=%b, required all zero", c, buttons, press_valid, rejected);
         else passes++;
      end
   endtask

   task automatic test_reject();
      logic [8:0] eb;
      do_reset();
      raw = 9'h101;
      for (int c = 1; c <= 12; c++) begin
         tick();
         checks++;
         if (buttons !== 9'h0 || press_valid !== 1'b0 || rejected !== (c == 7))
            $display("FAIL reject c=%0d: buttons=%b pv=%b rej=%b, required 0 0 %b", c, buttons, press_valid, rejected, c == 7);
         else passes++;
      end
      raw = '0;
      repeat (6) tick();
      raw = 9'h100;
      for (int c = 1; c <= 9; c++) begin
         tick();
         eb = (c == 7 || c == 8) ? 9'h100 : 9'h000;
         checks++;
         if (buttons !== eb || press_valid !== (c == 7))
            $display("FAIL reject_after c=%0d: buttons=%b pv=%b, required %b pv=%b", c, buttons, press_valid, eb, c == 7);
         else passes++;
      end
   endtask

   task automatic test_staggered();
      logic [8:0] eb;
      do_reset();
      raw = 9'h008;
      for (int c = 1; c <= 20; c++) begin
         if (c == 3) raw = 9'h028;
         tick();
         eb = (c == 7 || c == 8) ? 9'h008 : 9'h000;
         checks++;
         if (buttons !== eb || press_valid !== (c == 7) || rejected !== 1'b0)
            $display("FAIL staggered c=%0d: buttons=%b pv=%b rej=%b, required %b pv=%b rej=0", c, buttons, press_valid, rejected, eb, c == 7);
         else passes++;
      end
      raw = 9'h020;
      for (int c = 1; c <= 15; c++) begin
         tick();
         checks++;
         if (buttons !== 9'h0 || press_valid !== 1'b0)
            $display("FAIL partial_release c=%0d: buttons=%b pv=%b, required zero", c, buttons, press_valid);
         else passes++;
      end
      raw = '0;
      repeat (6) tick();
      raw = 9'h020;
      for (int c = 1; c <= 9; c++) begin
         tick();
         eb = (c == 7 || c == 8) ? 9'h020 : 9'h000;
         checks++;
         if (buttons !== eb || press_valid !== (c == 7))
            $display("FAIL staggered_next c=%0d: buttons=%b pv=%b, required %b pv=%b", c, buttons, press_valid, eb, c == 7);
         else passes++;
      end
   endtask

   task automatic test_reset_mid();
      logic [8:0] eb;
      do_reset();
      raw = 9'h010;
      repeat (7) tick();
      checks++;
      if (buttons !== 9'h010 || press_valid !== 1'b1)
         $display("FAIL mid_active: buttons=%b pv=%b, required 000010000 pv=1", buttons, press_valid);
      else passes++;
      resetn = 1'b0;
      #1;
      checks++;
      if (buttons !== 9'h0 || press_valid !== 1'b0 || rejected !== 1'b0)
         $display("FAIL async_clear: buttons=%b pv=%b rej=%b, required all zero", buttons, press_valid, rejected);
      else passes++;
      tick();
      resetn = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         tick();
         eb = (c == 7 || c == 8) ? 9'h010 : 9'h000;
         checks++;
         if (buttons !== eb || press_valid !== (c == 7))
            $display("FAIL repress c=%0d: buttons=%b pv=%b, required %b pv=%b", c, buttons, press_valid, eb, c == 7);
         else passes++;
      end
      raw = '0;
      repeat (8) tick();
   endtask

   task automatic test_early_release();
      logic [8:0] eb, eb1;
      do_reset();
      raw = 9'h040;
      for (int c = 1; c <= 14; c++) begin
         tick();
         if (c == 5) raw = '0;
         eb  = (c == 7 || c == 8) ? 9'h040 : 9'h000;
         eb1 = (c == 7) ? 9'h040 : 9'h000;
         checks++;
         if (buttons !== eb || b1 !== eb1 || pv1 !== (c == 7))
            $display("FAIL early_release c=%0d: buttons=%b b1=%b pv1=%b, required %b %b pv1=%b", c, buttons, b1, pv1, eb, eb1, c == 7);
         else passes++;
      end
      raw = 9'h080;
      for (int c = 1; c <= 9; c++) begin
         tick();
         eb1 = (c == 7) ? 9'h080 : 9'h000;
         checks++;
         if (b1 !== eb1 || pv1 !== (c == 7) || rj1 !== 1'b0)
            $display("FAIL p1_next c=%0d: b1=%b pv1=%b rj1=%b, required %b pv1=%b rj1=0", c, b1, pv1, rj1, eb1, c == 7);
         else passes++;
      end
      raw = '0;
      repeat (8) tick();
   endtask

   initial begin
      raw = '0;
      resetn = 1'b0;
      test_reset();
      test_press();
      test_bounce();
      test_reject();
      test_staggered();
      test_reset_mid();
      test_early_release();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
